// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_pkg
// Brief   : Shared state encoding and time-field constants for the stopwatch.
// Revision: 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int TIME_W  = 6;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_ctrl_if
// Brief   : Command, seconds-counter and result signals of the stopwatch block.
// Revision: 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic              start_stop;
    logic              clear;
    logic              lap;
    logic [TIME_W-1:0] cnt_seconds;
    logic              cnt_rollover;
    logic              cnt_enable;
    logic              cnt_reset;
    logic [TIME_W-1:0] minutes;
    logic              lap_valid;
    logic [TIME_W-1:0] lap_minutes;
    logic [TIME_W-1:0] lap_seconds;
    logic [1:0]        state;

    modport master (
        output start_stop, clear, lap, cnt_seconds, cnt_rollover,
        input  cnt_enable, cnt_reset, minutes, lap_valid, lap_minutes,
               lap_seconds, state
    );

    modport slave (
        input  start_stop, clear, lap, cnt_seconds, cnt_rollover,
        output cnt_enable, cnt_reset, minutes, lap_valid, lap_minutes,
               lap_seconds, state
    );

endinterface : stopwatch_ctrl_if
`default_nettype wire

// File: rtl/stopwatch_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Brief   : Divides clk by TICK_DIV while running; phase held when not running.
// Revision: 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 100000000
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  run,
    input  wire  clr,
    output logic tick
);

    localparam int                c_CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (run) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
                r_tick  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_tick  <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_ctrl
// Brief   : Stopwatch control FSM, minutes counter and lap capture.
// Revision: 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  wire              clk,
    input  wire              rst_n,
    stopwatch_ctrl_if.slave  sw
);

    state_t            r_state;
    logic              r_cnt_reset;
    logic [TIME_W-1:0] r_minutes;
    logic              r_lap_valid;
    logic [TIME_W-1:0] r_lap_minutes;
    logic [TIME_W-1:0] r_lap_seconds;
    logic              w_run;
    logic              w_tick;

    assign w_run = (r_state == ST_RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .clr   (sw.clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt_reset   <= 1'b0;
            r_minutes     <= '0;
            r_lap_valid   <= 1'b0;
            r_lap_minutes <= '0;
            r_lap_seconds <= '0;
        end else begin
            r_cnt_reset <= sw.clear;
            r_lap_valid <= 1'b0;

            if (sw.clear) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:  if (sw.start_stop) r_state <= ST_RUN;
                    ST_RUN:   if (sw.start_stop) r_state <= ST_PAUSE;
                    ST_PAUSE: if (sw.start_stop) r_state <= ST_RUN;
                    default:  r_state <= ST_IDLE;
                endcase
            end

            if (sw.clear) begin
                r_minutes <= '0;
            end else if (sw.cnt_rollover) begin
                r_minutes <= (r_minutes == TIME_W'(MIN_MAX)) ? '0 : r_minutes + 1'b1;
            end

            // Capture uses this cycle's minutes, i.e. before any rollover increment.
            if (!sw.clear && sw.lap && (r_state == ST_RUN || r_state == ST_PAUSE)) begin
                r_lap_minutes <= r_minutes;
                r_lap_seconds <= sw.cnt_seconds;
                r_lap_valid   <= 1'b1;
            end
        end
    end

    // A tick landing on the pausing edge is dropped so no enable leaks into PAUSE.
    assign sw.cnt_enable  = w_tick & w_run;
    assign sw.cnt_reset   = r_cnt_reset;
    assign sw.minutes     = r_minutes;
    assign sw.lap_valid   = r_lap_valid;
    assign sw.lap_minutes = r_lap_minutes;
    assign sw.lap_seconds = r_lap_seconds;
    assign sw.state       = r_state;

endmodule : stopwatch_ctrl
`default_nettype wire
